line_merge_buffer: RTL and testbench



---
 rtl/lc3b_types.sv | 19 +
 rtl/line_merge_buffer_merge.sv | 28 ++
 rtl/line_merge_buffer.sv | 134 +++++++++++++
 tb/tb_line_merge_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types for the write-combining line buffer.
// Word, line, mask and state definitions reused by the L1 write path.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [15:0]  lc3b_line_mask;
  typedef logic [2:0]   lc3b_offset;
  typedef logic [11:0]  lc3b_line_tag;

  typedef enum logic [1:0] {
    LMB_IDLE,
    LMB_FILL,
    LMB_DRAIN
  } lmb_state_t;

  localparam lc3b_line_mask LMB_FULL_MASK = 16'hFFFF;

endpackage

// File: rtl/line_merge_buffer_merge.sv
// Byte-enable merge of one 16-bit word into a 128-bit line and its mask.
// Pure combinational; also usable by the L1 write-hit path.
module line_word_merge
  import lc3b_types::*;
(
  input  lc3b_line      line_in,
  input  lc3b_line_mask mask_in,
  input  lc3b_offset    offset,
  input  lc3b_word      data,
  input  logic [1:0]    be,
  output lc3b_line      line_out,
  output lc3b_line_mask mask_out
);

  always_comb begin
    line_out = line_in;
    mask_out = mask_in;
    if (be[0]) begin
      line_out[{offset, 4'd0} +: 8] = data[7:0];
      mask_out[{offset, 1'b0}]      = 1'b1;
    end
    if (be[1]) begin
      line_out[{offset, 4'd8} +: 8] = data[15:8];
      mask_out[{offset, 1'b1}]      = 1'b1;
    end
  end

endmodule

// File: rtl/line_merge_buffer.sv
// Write-combining line assembler: merges byte-enabled word writes into
// one line and drains it to memory over a valid/ready handshake.
module line_merge_buffer
  import lc3b_types::*;
#(
  parameter int TAG_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic [TAG_W+3:0] word_addr,
  input  logic [15:0]      word_data,
  input  logic [1:0]       word_be,
  input  logic             flush,
  output logic             line_valid,
  input  logic             line_ready,
  output logic [TAG_W+3:0] line_addr,
  output logic [127:0]     line_data,
  output logic [15:0]      line_mask,
  output logic             empty
);

  lmb_state_t state_q, state_d;

  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] word_tag;
  lc3b_line         data_q;
  lc3b_line         merged_line;
  lc3b_line_mask    mask_q;
  lc3b_line_mask    merged_mask;

  logic valid_q;
  logic is_idle, is_fill, is_drain;
  logic tag_hit, accept;
  logic load_tag, do_merge, clear;
  logic unused_addr_lsb;

  assign unused_addr_lsb = word_addr[0];

  assign word_tag = word_addr[TAG_W+3:4];
  assign tag_hit  = (word_tag == tag_q);

  assign is_idle  = (state_q == LMB_IDLE);
  assign is_fill  = (state_q == LMB_FILL);
  assign is_drain = (state_q == LMB_DRAIN);

  // flush masks a same-cycle word so the drain always wins
  assign word_ready = is_idle
                   || (is_fill && tag_hit && !flush);
  assign accept     = word_valid && word_ready;
  assign empty      = is_idle;

  assign line_valid = valid_q;
  assign line_addr  = {tag_q, 4'b0000};
  assign line_data  = data_q;
  assign line_mask  = mask_q;

  line_word_merge u_merge (
    .line_in  (data_q),
    .mask_in  (mask_q),
    .offset   (word_addr[3:1]),
    .data     (word_data),
    .be       (word_be),
    .line_out (merged_line),
    .mask_out (merged_mask)
  );

  always_comb begin
    state_d  = state_q;
    load_tag = 1'b0;
    do_merge = 1'b0;
    clear    = 1'b0;
    unique case (1'b1)
      is_idle: begin
        if (accept) begin
          load_tag = 1'b1;
          do_merge = 1'b1;
          state_d  = (merged_mask == LMB_FULL_MASK)
                   ? LMB_DRAIN : LMB_FILL;
        end
      end
      is_fill: begin
        if (flush) begin
          if (mask_q != '0) begin
            state_d = LMB_DRAIN;
          end else begin
            clear   = 1'b1;
            state_d = LMB_IDLE;
          end
        end else if (accept) begin
          do_merge = 1'b1;
          if (merged_mask == LMB_FULL_MASK)
            state_d = LMB_DRAIN;
        end else if (word_valid) begin
          // tag miss: push the line out, requester retries
          state_d = LMB_DRAIN;
        end
      end
      is_drain: begin
        if (line_ready) begin
          clear   = 1'b1;
          state_d = LMB_IDLE;
        end
      end
      default: begin
        state_d = LMB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LMB_IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == LMB_DRAIN);
      if (load_tag)
        tag_q <= word_tag;
      if (clear) begin
        data_q <= '0;
        mask_q <= '0;
      end else if (do_merge) begin
        data_q <= merged_line;
        mask_q <= merged_mask;
      end
    end
  end

endmodule

// File: tb/tb_line_merge_buffer.sv
// Directed and randomized checks of line_merge_buffer against a
// byte-array reference of the pending line.
module tb_line_merge_buffer;

  logic         clk;
  logic         rst_n;
  logic         word_valid;
  logic         word_ready;
  logic [15:0]  word_addr;
  logic [15:0]  word_data;
  logic [1:0]   word_be;
  logic         flush;
  logic         line_valid;
  logic         line_ready;
  logic [15:0]  line_addr;
  logic [127:0] line_data;
  logic [15:0]  line_mask;
  logic         empty;

  int n_vec;
  int n_err;

  line_merge_buffer #(.TAG_W(12)) dut (
    .clk        (clk),
    .reset_n    (rst_n),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_addr  (word_addr),
    .word_data  (word_data),
    .word_be    (word_be),
    .flush      (flush),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_addr  (line_addr),
    .line_data  (line_data),
    .line_mask  (line_mask),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    word_valid = 1'b0;
    word_addr  = '0;
    word_data  = '0;
    word_be    = 2'b00;
    flush      = 1'b0;
    line_ready = 1'b0;
  endtask

  // reference model: pending line as bytes plus open/draining flags
  logic [7:0]  m_byte [16];
  logic [15:0] m_mask;
  logic [11:0] m_tag;
  bit          m_open;
  bit          m_drain;

  function automatic logic [127:0] m_line();
    logic [127:0] l;
    for (int b = 0; b < 16; b++) l[8*b +: 8] = m_byte[b];
    return l;
  endfunction

  task automatic m_clear();
    for (int b = 0; b < 16; b++) m_byte[b] = 8'h00;
    m_mask = '0;
  endtask

  task automatic m_write(input logic [15:0] a,
                         input logic [15:0] d,
                         input logic [1:0] be);
    int k;
    k = int'(a[3:1]);
    for (int h = 0; h < 2; h++) begin
      if (be[h]) begin
        m_byte[2*k+h]    = d[8*h +: 8];
        m_mask[2*k+h]    = 1'b1;
      end
    end
  endtask

  task automatic m_edge();
    logic hit;
    hit = (word_addr[15:4] == m_tag);
    if (m_drain) begin
      if (line_ready) begin
        m_drain = 0;
        m_clear();
      end
    end else if (!m_open) begin
      if (word_valid) begin
        m_tag  = word_addr[15:4];
        m_write(word_addr, word_data, word_be);
        m_open = 1;
      end
    end else if (flush) begin
      m_open  = 0;
      m_drain = (m_mask != 0);
      if (m_mask == 0) m_clear();
    end else if (word_valid && hit) begin
      m_write(word_addr, word_data, word_be);
      if (m_mask == 16'hFFFF) begin
        m_open  = 0;
        m_drain = 1;
      end
    end else if (word_valid) begin
      m_open  = 0;
      m_drain = 1;
    end
  endtask

  logic [127:0] exp_line;
  logic [127:0] snap_data;

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_in();
    rst_n = 1'b0;
    #12;

    // reset state
    chk("rst_line_valid", 128'(line_valid), 128'(1'b0));
    chk("rst_empty",      128'(empty),      128'(1'b1));
    chk("rst_word_ready", 128'(word_ready), 128'(1'b1));
    chk("rst_mask",       128'(line_mask),  128'(16'h0));
    chk("rst_data",       line_data,        128'h0);
    rst_n = 1'b1;
    tick();

    // full line
    exp_line = '0;
    for (int i = 0; i < 8; i++) begin
      word_valid = 1'b1;
      word_addr  = 16'h1230 + 16'(2*i);
      word_data  = 16'hA000 + 16'(i);
      word_be    = 2'b11;
      exp_line[16*i +: 16] = 16'hA000 + 16'(i);
      #1;
      chk("full_ready", 128'(word_ready), 128'(1'b1));
      chk("full_no_valid", 128'(line_valid), 128'(1'b0));
      tick();
    end
    idle_in();
    #1;
    chk("full_valid", 128'(line_valid), 128'(1'b1));
    chk("full_addr",  128'(line_addr),  128'(16'h1230));
    chk("full_mask",  128'(line_mask),  128'(16'hFFFF));
    chk("full_data",  line_data,        exp_line);
    chk("full_wr_rdy", 128'(word_ready), 128'(1'b0));
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    #1;
    chk("full_empty",  128'(empty),      128'(1'b1));
    chk("full_valid0", 128'(line_valid), 128'(1'b0));
    chk("full_mask0",  128'(line_mask),  128'(16'h0));

    // partial line then flush
    word_valid = 1'b1;
    word_addr  = 16'h4006;
    word_data  = 16'h00BB;
    word_be    = 2'b01;
    tick();
    idle_in();
    flush = 1'b1;
    #1;
    chk("pf_ready_flush", 128'(word_ready), 128'(1'b0));
    tick();
    flush = 1'b0;
    #1;
    exp_line = '0;
    exp_line[55:48] = 8'hBB;
    chk("pf_valid", 128'(line_valid), 128'(1'b1));
    chk("pf_mask",  128'(line_mask),  128'(16'h0040));
    chk("pf_data",  line_data,        exp_line);
    chk("pf_addr",  128'(line_addr),  128'(16'h4000));
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;

    // tag miss drain, then retried word lands in a fresh line
    word_valid = 1'b1;
    word_addr  = 16'h2000;
    word_data  = 16'h1234;
    word_be    = 2'b11;
    tick();
    word_addr  = 16'h2010;
    word_data  = 16'h5678;
    #1;
    chk("tm_ready0", 128'(word_ready), 128'(1'b0));
    tick();
    exp_line = 128'h1234;
    chk("tm_valid", 128'(line_valid), 128'(1'b1));
    chk("tm_mask",  128'(line_mask),  128'(16'h0003));
    chk("tm_addr",  128'(line_addr),  128'(16'h2000));
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("tm_hold_valid", 128'(line_valid), 128'(1'b1));
      chk("tm_hold_data",  line_data,        exp_line);
      chk("tm_hold_mask",  128'(line_mask),  128'(16'h0003));
      chk("tm_hold_addr",  128'(line_addr),  128'(16'h2000));
      chk("tm_hold_rdy",   128'(word_ready), 128'(1'b0));
    end
    line_ready = 1'b1;
    #1;
    chk("tm_hs_rdy", 128'(word_ready), 128'(1'b0));
    tick();
    line_ready = 1'b0;
    #1;
    chk("tm_post_rdy", 128'(word_ready), 128'(1'b1));
    tick();
    idle_in();
    #1;
    chk("tm_new_empty", 128'(empty),     128'(1'b0));
    chk("tm_new_addr",  128'(line_addr), 128'(16'h2010));
    chk("tm_new_mask",  128'(line_mask), 128'(16'h0003));
    chk("tm_new_data",  line_data,       128'h5678);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;

    // overwrite and byte lanes
    word_valid = 1'b1;
    word_addr  = 16'h3002;
    word_data  = 16'h1111;
    word_be    = 2'b11;
    tick();
    word_data  = 16'h22FF;
    word_be    = 2'b10;
    tick();
    idle_in();
    #1;
    chk("ow_mask",  128'(line_mask),          128'(16'h000C));
    chk("ow_word1", 128'(line_data[31:16]),   128'(16'h2211));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ow_valid", 128'(line_valid), 128'(1'b1));
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;

    // flush in IDLE ignored; be=00 then flush returns to IDLE
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("if_empty", 128'(empty),      128'(1'b1));
    chk("if_valid", 128'(line_valid), 128'(1'b0));
    word_valid = 1'b1;
    word_addr  = 16'h5008;
    word_data  = 16'hFFFF;
    word_be    = 2'b00;
    tick();
    idle_in();
    #1;
    chk("be0_fill", 128'(empty),     128'(1'b0));
    chk("be0_mask", 128'(line_mask), 128'(16'h0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("be0_valid", 128'(line_valid), 128'(1'b0));
    chk("be0_empty", 128'(empty),      128'(1'b1));
    chk("be0_mask2", 128'(line_mask),  128'(16'h0));

    // asynchronous reset while draining
    word_valid = 1'b1;
    word_addr  = 16'h6004;
    word_data  = 16'hCAFE;
    word_be    = 2'b11;
    tick();
    idle_in();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("rd_valid", 128'(line_valid), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rd_valid0", 128'(line_valid), 128'(1'b0));
    chk("rd_mask0",  128'(line_mask),  128'(16'h0));
    chk("rd_data0",  line_data,        128'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rd_empty", 128'(empty),      128'(1'b1));
    chk("rd_ready", 128'(word_ready), 128'(1'b1));

    // randomized traffic against the reference model
    m_clear();
    m_tag   = '0;
    m_open  = 0;
    m_drain = 0;
    for (int n = 0; n < 400; n++) begin
      word_valid = ($urandom_range(0, 9) < 7);
      word_addr  = {($urandom_range(0, 7) == 0) ? 12'h0AC : 12'h0AB,
                    4'($urandom_range(0, 15))};
      word_data  = 16'($urandom);
      word_be    = 2'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 11) == 0);
      line_ready = ($urandom_range(0, 1) == 1);
      #1;
      chk("rnd_word_ready", 128'(word_ready),
          128'(!m_drain && (!m_open ||
               (word_addr[15:4] == m_tag && !flush))));
      chk("rnd_line_valid", 128'(line_valid), 128'(m_drain));
      chk("rnd_empty",      128'(empty),      128'(!m_open && !m_drain));
      chk("rnd_mask",       128'(line_mask),  128'(m_mask));
      chk("rnd_data",       line_data,        m_line());
      chk("rnd_addr",       128'(line_addr),  128'({m_tag, 4'h0}));
      @(posedge clk);
      m_edge();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
